// File: rtl/perceptron_pkg.sv
// Shared sizes, segment codes, cfg field layout and
// saturating step helper for the perceptron tile.
package perceptron_pkg;

  localparam int NUM_IN = 8;
  localparam int W_BITS = 4;
  localparam int B_BITS = 8;
  localparam int SUM_BITS = 9;
  localparam int CFG_BITS = NUM_IN * W_BITS + B_BITS;
  localparam int BIAS_LSB = NUM_IN * W_BITS;
  localparam int CFG_MSB = CFG_BITS - 1;

  localparam logic [6:0] SEG_ZERO = 7'h3F;
  localparam logic [6:0] SEG_ONE = 7'h06;

  localparam logic signed [7:0] W_MIN = -8'sd8;
  localparam logic signed [7:0] W_MAX = 8'sd7;
  localparam logic signed [7:0] B_MIN = -8'sd128;
  localparam logic signed [7:0] B_MAX = 8'sd127;

  function automatic logic signed [7:0] sat_step(
    input logic signed [7:0] v,
    input logic up,
    input logic signed [7:0] lo,
    input logic signed [7:0] hi
  );
    logic signed [7:0] r;
    if (up) r = (v >= hi) ? hi : v + 8'sd1;
    else r = (v <= lo) ? lo : v - 8'sd1;
    return r;
  endfunction

endpackage

// File: rtl/perceptron_core.sv
// Weighted sum, fire decision and the perceptron
// learning step, all combinational.
module perceptron_core
  import perceptron_pkg::*;
(
  input  logic [NUM_IN-1:0]          x,
  input  logic [CFG_BITS-1:0]        cfg,
  input  logic                       t,
  input  logic                       train_pulse,
  output logic signed [SUM_BITS-1:0] sum,
  output logic                       y_next,
  output logic [CFG_BITS-1:0]        cfg_trained,
  output logic                       upd_next
);

  logic [B_BITS-1:0] bias;
  logic [W_BITS-1:0] w;
  logic [7:0] wx;
  logic [7:0] bx;

  assign bias = cfg[BIAS_LSB +: B_BITS];

  always_comb begin
    w = '0;
    sum = {bias[B_BITS-1], bias};
    for (int i = 0; i < NUM_IN; i++) begin
      w = cfg[i*W_BITS +: W_BITS];
      if (x[i])
        sum = sum + {{(SUM_BITS-W_BITS){w[W_BITS-1]}}, w};
    end
  end

  assign y_next = !sum[SUM_BITS-1] && (sum != '0);
  assign upd_next = train_pulse && (y_next != t);

  // Only active inputs move their weight; bias always moves.
  always_comb begin
    cfg_trained = cfg;
    wx = '0;
    bx = '0;
    if (upd_next) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (x[i]) begin
          wx = sat_step(
            {{(8-W_BITS){cfg[i*W_BITS+W_BITS-1]}},
             cfg[i*W_BITS +: W_BITS]},
            t, W_MIN, W_MAX);
          cfg_trained[i*W_BITS +: W_BITS] = wx[W_BITS-1:0];
        end
      end
      bx = sat_step(bias, t, B_MIN, B_MAX);
      cfg_trained[BIAS_LSB +: B_BITS] = bx;
    end
  end

endmodule

// File: rtl/perceptron_neuromeme.sv
// TinyTapeout top: config shifter, train edge detect,
// output register and pin mapping.
module perceptron_neuromeme
  import perceptron_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [CFG_BITS-1:0] cfg;
  logic [CFG_BITS-1:0] cfg_trained;
  logic signed [SUM_BITS-1:0] sum;
  logic y;
  logic y_next;
  logic upd;
  logic upd_next;
  logic train_q;
  logic shift_en;
  logic shift_din;
  logic train_pulse;
  logic unused;

  assign shift_en = uio_in[0];
  assign shift_din = uio_in[1];
  // Shift wins: an edge seen while shifting is swallowed.
  assign train_pulse = uio_in[2] && !train_q && !shift_en;

  perceptron_core u_core (
    .x           (ui_in),
    .cfg         (cfg),
    .t           (uio_in[3]),
    .train_pulse (train_pulse),
    .sum         (sum),
    .y_next      (y_next),
    .cfg_trained (cfg_trained),
    .upd_next    (upd_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
      y <= 1'b0;
      upd <= 1'b0;
      train_q <= 1'b0;
    end else if (ena) begin
      train_q <= uio_in[2];
      y <= y_next;
      if (shift_en) begin
        cfg <= {cfg[CFG_MSB-1:0], shift_din};
      end else if (train_pulse) begin
        cfg <= cfg_trained;
        upd <= upd_next;
      end
    end
  end

  assign uo_out = {y, y ? SEG_ONE : SEG_ZERO};
  assign uio_out = {1'b0, upd, y, cfg[CFG_MSB], 4'b0000};
  assign uio_oe = 8'hF0;
  assign unused = ^{uio_in[7:4], sum};

endmodule

// File: tb/tb_perceptron_neuromeme.sv
// Scoreboard bench: stimulus queues expected pins per cycle,
// a negedge monitor pops and compares.
module tb_perceptron_neuromeme;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  typedef struct {
    int cyc;
    string name;
    logic [7:0] uo;
    logic [7:0] uo_m;
    logic [7:0] uio;
    logic [7:0] uio_m;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  perceptron_neuromeme dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: stale entry, due %0d now %0d",
                 e.name, e.cyc, cyc);
      end else if ((uo_out & e.uo_m) !== (e.uo & e.uo_m) ||
                   (uio_out & e.uio_m) !== (e.uio & e.uio_m) ||
                   uio_oe !== 8'hF0) begin
        errors++;
        $display("FAIL %s: got uo=%h uio=%h oe=%h want uo=%h uio=%h (masks %h/%h) oe=f0",
                 e.name, uo_out, uio_out, uio_oe,
                 e.uo, e.uio, e.uo_m, e.uio_m);
      end
    end
  end

  task automatic push(input string n, input logic [7:0] uo,
                      input logic [7:0] uom, input logic [7:0] uio,
                      input logic [7:0] uiom, input int dly);
    exp_t e;
    e.cyc = cyc + dly;
    e.name = n;
    e.uo = uo;
    e.uo_m = uom;
    e.uio = uio;
    e.uio_m = uiom;
    q.push_back(e);
  endtask

  task automatic chk(input string n, input logic [7:0] uo,
                     input logic [7:0] uio);
    push(n, uo, 8'hFF, uio, 8'hFF, 1);
  endtask

  task automatic step(input logic [7:0] ui, input logic [7:0] u,
                      input logic en = 1'b1);
    @(posedge clk);
    #2;
    ui_in = ui;
    uio_in = u;
    ena = en;
  endtask

  task automatic do_reset(input string n);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    ui_in = 8'h00;
    uio_in = 8'h00;
    ena = 1'b1;
    push(n, 8'h3F, 8'hFF, 8'h00, 8'hFF, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [39:0] w, input logic [7:0] ui,
                      input logic tog);
    for (int i = 39; i >= 0; i--)
      step(ui, {4'b0, 1'b0, tog & (i % 2 == 1), w[i], 1'b1});
  endtask

  task automatic readback(input string n, input logic [39:0] w);
    step(8'h00, 8'h00);
    push(n, 8'h00, 8'h00, {3'b0, w[39], 4'b0}, 8'h10, 1);
    for (int k = 1; k <= 40; k++) begin
      step(8'h00, 8'h01);
      push(n, 8'h00, 8'h00,
           {3'b0, (k < 40) ? w[39-k] : 1'b0, 4'b0}, 8'h10, 1);
    end
  endtask

  initial begin
    do_reset("reset");
    step(8'hFF, 8'h00);
    chk("release_s0", 8'h3F, 8'h00);

    load(40'hFD_0000_0022, 8'h00, 1'b0);
    step(8'h01, 8'h00);
    chk("sum_m1", 8'h3F, 8'h10);
    step(8'h03, 8'h00);
    chk("sum_p1", 8'h86, 8'h30);
    readback("readback_a", 40'hFD_0000_0022);

    do_reset("reset_mid");
    step(8'h05, 8'h0C);
    chk("train1", 8'h3F, 8'h40);
    step(8'h05, 8'h08);
    chk("train1_y", 8'h86, 8'h60);
    step(8'h05, 8'h0C);
    chk("train2", 8'h86, 8'h20);
    step(8'h05, 8'h08);
    chk("train2_hold", 8'h86, 8'h20);
    step(8'h04, 8'h00);
    chk("w2_only", 8'h86, 8'h20);
    step(8'h02, 8'h00);
    chk("w1_zero", 8'h86, 8'h20);

    load(40'h7F_0000_0008, 8'hFF, 1'b1);
    step(8'h01, 8'h00);
    chk("prio_load", 8'h86, 8'h20);
    step(8'h01, 8'h04);
    chk("sat_train", 8'h86, 8'h60);
    step(8'h01, 8'h00);
    chk("sat_s118", 8'h86, 8'h60);
    readback("readback_sat", 40'h7E_0000_0008);

    step(8'h00, 8'h00);
    chk("pre_ena", 8'h3F, 8'h40);
    for (int i = 0; i < 3; i++) begin
      step(8'hFF, 8'h0F, 1'b0);
      chk("ena_low", 8'h3F, 8'h40);
    end
    step(8'hFF, 8'h0C);
    chk("ena_train", 8'h3F, 8'h40);
    step(8'hFF, 8'h00);
    chk("ena_train_y", 8'h86, 8'h60);

    step(8'hFF, 8'h03);
    step(8'hFF, 8'h03);
    do_reset("reset_shift");
    step(8'hFF, 8'h00);
    chk("post_reset", 8'h3F, 8'h00);

    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
